// File: rtl/priority_arb_n_v_pkg.sv
// Shared definitions for the N-input priority / round-robin arbiter.
package priority_arb_n_v_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Index arithmetic that stays correct for non-power-of-2 N.
    function automatic int unsigned mod_add(int unsigned a, int unsigned b, int unsigned n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/priority_enc_n_v.sv
// Combinational find-first over unmasked requests, searching upward from a start
// index and wrapping N-1 -> 0.
module priority_enc_n_v
    import priority_arb_n_v_pkg::*;
#(
    parameter int N      = 4,
    parameter int CODE_W = $clog2(N)
) (
    input  logic [N-1:0]      req_i,
    input  logic [N-1:0]      mask_i,
    input  logic [CODE_W-1:0] start_i,
    output logic [CODE_W-1:0] code_o,
    output logic              found_o
);

    logic [N-1:0]   eligible;
    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;

    // Two copies side by side turn the wrap-around search into a plain shift.
    assign eligible = req_i & ~mask_i;
    assign doubled  = {eligible, eligible};
    assign rotated  = N'(doubled >> start_i);

    always_comb begin
        code_o  = '0;
        found_o = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found_o && rotated[i]) begin
                found_o = 1'b1;
                code_o  = CODE_W'(mod_add(32'(start_i), i, N));
            end
        end
    end

endmodule

// File: rtl/priority_arb_n_v.sv
// Registered N-input arbiter: fixed priority or round-robin, grant held while
// requested, optional max-hold timeout with forced release.
module priority_arb_n_v
    import priority_arb_n_v_pkg::*;
#(
    parameter int N        = 4,
    parameter int MODE     = MODE_FIXED,
    parameter int MAX_HOLD = 0,
    parameter int CODE_W   = $clog2(N)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N-1:0]      i_req,
    output logic [CODE_W-1:0] o_code,
    output logic [N-1:0]      o_grant,
    output logic              o_valid,
    output logic              o_timeout
);

    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    arb_state_e        state_q;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] rr_ptr_q;
    logic [N-1:0]      grant_q;
    logic              valid_q;
    logic              timeout_q;
    logic [HOLD_W-1:0] hold_q;

    logic [CODE_W-1:0] start_d;
    logic [N-1:0]      mask_d;
    logic [CODE_W-1:0] win_code;
    logic              win_found;
    logic              released;
    logic              expired;

    assign released = (state_q == ST_GRANT) && !i_req[code_q];
    assign expired  = (MAX_HOLD > 0) && (state_q == ST_GRANT) && i_req[code_q]
                      && (int'(hold_q) == MAX_HOLD - 1);

    // In GRANT the search starts just past the current owner, i.e. at the
    // rr_ptr value that this grant change is about to register.
    always_comb begin
        start_d = '0;
        mask_d  = '0;
        if (state_q == ST_GRANT) begin
            if (MODE == MODE_RR) start_d = CODE_W'(mod_add(32'(code_q), 1, N));
            if (expired) mask_d[code_q] = 1'b1;
        end else if (MODE == MODE_RR) begin
            start_d = rr_ptr_q;
        end
    end

    priority_enc_n_v #(
        .N      (N),
        .CODE_W (CODE_W)
    ) u_enc (
        .req_i   (i_req),
        .mask_i  (mask_d),
        .start_i (start_d),
        .code_o  (win_code),
        .found_o (win_found)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            code_q    <= '0;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        state_q <= ST_GRANT;
                        code_q  <= win_code;
                        grant_q <= N'(1) << win_code;
                        valid_q <= 1'b1;
                        hold_q  <= '0;
                    end
                end
                ST_GRANT: begin
                    if (released || expired) begin
                        if (MODE == MODE_RR) rr_ptr_q <= CODE_W'(mod_add(32'(code_q), 1, N));
                        hold_q <= '0;
                        if (win_found) begin
                            code_q    <= win_code;
                            grant_q   <= N'(1) << win_code;
                            timeout_q <= expired;
                        end else if (expired) begin
                            timeout_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            code_q  <= '0;
                            grant_q <= '0;
                            valid_q <= 1'b0;
                        end
                    end else if (MAX_HOLD > 0) begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
            endcase
        end
    end

    assign o_code    = code_q;
    assign o_grant   = grant_q;
    assign o_valid   = valid_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_priority_arb_n_v.sv
// Bench for priority_arb_n_v: five configurations checked against an ownership model.
module tb_priority_arb_n_v;

    typedef struct {
        bit valid;
        int code;
        int held;
        int ptr;
        bit tout;
    } mdl_t;

    localparam int NN [5] = '{4, 4, 4, 5, 4};
    localparam int MD [5] = '{0, 1, 0, 1, 1};
    localparam int MH [5] = '{0, 2, 3, 0, 0};

    logic clk = 1'b0;
    logic rst;
    logic [3:0] req0, req1, req2, req4;
    logic [4:0] req3;

    logic [1:0] code0, code1, code2, code4;
    logic [2:0] code3;
    logic [3:0] grant0, grant1, grant2, grant4;
    logic [4:0] grant3;
    logic valid0, valid1, valid2, valid3, valid4;
    logic tout0, tout1, tout2, tout3, tout4;

    int tests = 0;
    int fails = 0;
    mdl_t m [5];

    always #5 clk = ~clk;

    priority_arb_n_v #(.N(4), .MODE(0), .MAX_HOLD(0)) u0 (
        .i_clk(clk), .i_rst(rst), .i_req(req0),
        .o_code(code0), .o_grant(grant0), .o_valid(valid0), .o_timeout(tout0));
    priority_arb_n_v #(.N(4), .MODE(1), .MAX_HOLD(2)) u1 (
        .i_clk(clk), .i_rst(rst), .i_req(req1),
        .o_code(code1), .o_grant(grant1), .o_valid(valid1), .o_timeout(tout1));
    priority_arb_n_v #(.N(4), .MODE(0), .MAX_HOLD(3)) u2 (
        .i_clk(clk), .i_rst(rst), .i_req(req2),
        .o_code(code2), .o_grant(grant2), .o_valid(valid2), .o_timeout(tout2));
    priority_arb_n_v #(.N(5), .MODE(1), .MAX_HOLD(0)) u3 (
        .i_clk(clk), .i_rst(rst), .i_req(req3),
        .o_code(code3), .o_grant(grant3), .o_valid(valid3), .o_timeout(tout3));
    priority_arb_n_v #(.N(4), .MODE(1), .MAX_HOLD(0)) u4 (
        .i_clk(clk), .i_rst(rst), .i_req(req4),
        .o_code(code4), .o_grant(grant4), .o_valid(valid4), .o_timeout(tout4));

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.valid = 1'b0; r.code = 0; r.held = 0; r.ptr = 0; r.tout = 1'b0;
        return r;
    endfunction

    // Winner among requesters other than excl: lowest index, or first from start upward.
    function automatic int pick(bit [7:0] req, int n, int mode, int start, int excl);
        for (int i = 0; i < n; i++) begin
            int idx = (mode == 1) ? (start + i) % n : i;
            if (req[idx] && idx != excl) return idx;
        end
        return -1;
    endfunction

    // One clock of ownership: held counts cycles the current owner has had the resource.
    function automatic mdl_t step(mdl_t cur, bit [7:0] req, int n, int mode, int maxh);
        mdl_t r = cur;
        int w;
        r.tout = 1'b0;
        if (!cur.valid) begin
            w = pick(req, n, mode, cur.ptr, -1);
            if (w >= 0) begin r.valid = 1'b1; r.code = w; r.held = 1; end
        end else if (!req[cur.code] || (maxh > 0 && cur.held == maxh)) begin
            bit forced = req[cur.code];
            if (mode == 1) r.ptr = (cur.code + 1) % n;
            w = pick(req, n, mode, (cur.code + 1) % n, forced ? cur.code : -1);
            if (w < 0 && forced) w = cur.code;
            if (w < 0) begin
                r.valid = 1'b0; r.code = 0; r.held = 0;
            end else begin
                r.code = w; r.held = 1; r.tout = forced;
            end
        end else begin
            r.held = cur.held + 1;
        end
        return r;
    endfunction

    function automatic bit [7:0] cur_req(int k);
        case (k)
            0: return 8'(req0);
            1: return 8'(req1);
            2: return 8'(req2);
            3: return 8'(req3);
            default: return 8'(req4);
        endcase
    endfunction

    function automatic logic [31:0] obs(int k);
        case (k)
            0: return {8'(grant0), 8'(code0), 7'b0, valid0, 7'b0, tout0};
            1: return {8'(grant1), 8'(code1), 7'b0, valid1, 7'b0, tout1};
            2: return {8'(grant2), 8'(code2), 7'b0, valid2, 7'b0, tout2};
            3: return {8'(grant3), 8'(code3), 7'b0, valid3, 7'b0, tout3};
            default: return {8'(grant4), 8'(code4), 7'b0, valid4, 7'b0, tout4};
        endcase
    endfunction

    function automatic logic [31:0] expv(int k);
        logic [7:0] g;
        g = m[k].valid ? (8'd1 << m[k].code) : 8'd0;
        return {g, 8'(m[k].code), 7'b0, m[k].valid, 7'b0, m[k].tout};
    endfunction

    task automatic cyc();
        bit [7:0] r [5];
        for (int k = 0; k < 5; k++) r[k] = cur_req(k);
        @(posedge clk);
        for (int k = 0; k < 5; k++)
            m[k] = rst ? mdl_reset() : step(m[k], r[k], NN[k], MD[k], MH[k]);
        #1;
    endtask

    task automatic test_reset();
        req0 = 4'b0110;
        cyc();
        tests++;
        if (obs(0) !== 32'h02010100) begin
            fails++; $display("FAIL reset_pre u0: got %h want %h", obs(0), 32'h02010100);
        end
        #3 rst = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (obs(k) !== 32'h0) begin
                fails++; $display("FAIL reset_async u%0d: got %h want %h", k, obs(k), 32'h0);
            end
            m[k] = mdl_reset();
        end
        req0 = 4'b0000;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_fixed();
        req0 = 4'b0110;
        cyc();
        tests++;
        if (obs(0) !== 32'h02010100) begin
            fails++; $display("FAIL fixed_first: got %h want %h", obs(0), 32'h02010100);
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            tests++;
            if (obs(0) !== 32'h02010100 || obs(0) !== expv(0)) begin
                fails++; $display("FAIL fixed_hold: got %h want %h", obs(0), 32'h02010100);
            end
        end
        req0 = 4'b0100;
        cyc();
        tests++;
        if (obs(0) !== 32'h04020100) begin
            fails++; $display("FAIL fixed_handover: got %h want %h", obs(0), 32'h04020100);
        end
        req0 = 4'b0000;
        cyc();
    endtask

    task automatic test_rr_timeout();
        logic [31:0] want;
        req1 = 4'b1111;
        for (int k = 1; k <= 12; k++) begin
            int c = ((k - 1) / 2) % 4;
            bit t = (k >= 3) && (k % 2 == 1);
            cyc();
            want = {8'(4'b1 << c), 8'(c), 8'h01, 7'b0, t};
            tests++;
            if (obs(1) !== want || obs(1) !== expv(1)) begin
                fails++; $display("FAIL rr_timeout k=%0d: got %h want %h", k, obs(1), want);
            end
        end
        req1 = 4'b0000;
        cyc();
    endtask

    task automatic test_single_timeout();
        logic [31:0] want;
        req2 = 4'b0100;
        for (int k = 1; k <= 10; k++) begin
            bit t = (k > 1) && (k % 3 == 1);
            cyc();
            want = {8'h04, 8'h02, 8'h01, 7'b0, t};
            tests++;
            if (obs(2) !== want) begin
                fails++; $display("FAIL single_timeout k=%0d: got %h want %h", k, obs(2), want);
            end
        end
        req2 = 4'b0000;
        cyc();
    endtask

    task automatic test_idle_pulse();
        req0 = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            cyc();
            tests++;
            if (obs(0) !== 32'h0) begin
                fails++; $display("FAIL idle_empty: got %h want %h", obs(0), 32'h0);
            end
        end
        req0 = 4'b1000;
        cyc();
        req0 = 4'b0000;
        tests++;
        if (obs(0) !== 32'h08030100) begin
            fails++; $display("FAIL idle_pulse_grant: got %h want %h", obs(0), 32'h08030100);
        end
        cyc();
        tests++;
        if (obs(0) !== 32'h0) begin
            fails++; $display("FAIL idle_pulse_release: got %h want %h", obs(0), 32'h0);
        end
    endtask

    task automatic test_rr_wrap();
        req4 = 4'b1000;
        req3 = 5'b10000;
        cyc();
        req4 = 4'b1001;
        req3 = 5'b10001;
        cyc();
        tests++;
        if (obs(4) !== 32'h08030100 || obs(3) !== 32'h10040100) begin
            fails++; $display("FAIL rr_wrap_hold: got %h/%h want %h/%h", obs(4), obs(3), 32'h08030100, 32'h10040100);
        end
        req4 = 4'b0001;
        req3 = 5'b00001;
        cyc();
        tests++;
        if (obs(4) !== 32'h01000100 || obs(3) !== 32'h01000100) begin
            fails++; $display("FAIL rr_wrap: got %h/%h want %h", obs(4), obs(3), 32'h01000100);
        end
        req4 = 4'b0000;
        req3 = 5'b00000;
        cyc();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req0 ^= 4'($urandom) & 4'($urandom);
            req1 ^= 4'($urandom) & 4'($urandom);
            req2 ^= 4'($urandom) & 4'($urandom);
            req3 ^= 5'($urandom) & 5'($urandom);
            req4 ^= 4'($urandom) & 4'($urandom);
            cyc();
            for (int k = 0; k < 5; k++) begin
                tests++;
                if (obs(k) !== expv(k)) begin
                    fails++; $display("FAIL random i=%0d u%0d: got %h want %h", i, k, obs(k), expv(k));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req0 = '0; req1 = '0; req2 = '0; req3 = '0; req4 = '0;
        for (int k = 0; k < 5; k++) m[k] = mdl_reset();
        cyc();
        cyc();
        rst = 1'b0;
        test_reset();
        test_fixed();
        test_rr_timeout();
        test_single_timeout();
        test_idle_pulse();
        test_rr_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
